exec_seq: RTL and testbench
===========================

EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  upstream instruction present.
REQ-005 in_ready  out  1  block can accept an instruction.
REQ-006 in_class  in  2  00 ALU reg/imm, 01 branch, 10/11 reserved (treated as 00).
REQ-007 in_funct3  in  3  RISC-V funct3.
REQ-008 in_sub  in  1  funct7[5]: selects sub (funct3 000) and sra (funct3 101).
REQ-009 in_src1, in_src2, in_pc, in_imm  in  32 each  operands; src2 already imm-muxed for ALU class.
REQ-010 alu_in1, alu_in2  out  32  ALU operands.
REQ-011 alu_op  out  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
REQ-012 alu_out  in  32  ALU result, registered inside the ALU (1-cycle latency).
REQ-013 zero, less_than, less_than_unsigned  in  1 each  registered ALU flags, same latency as alu_out.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_result  out  32  writeback value.
REQ-017 out_taken  out  1  branch taken.
REQ-018 out_target  out  32  branch target (in_pc + in_imm, mod 2^32).

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, RESP; transitions are IDLE->ISSUE on in_valid&in_ready, ISSUE->CAPTURE unconditionally, CAPTURE->RESP unconditionally, RESP->IDLE on out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE; acceptance registers class, funct3, sub, src1, src2 and target = pc+imm.
REQ-021 In ISSUE, alu_in1/alu_in2 SHALL be the captured src1/src2 and alu_op the decoded op; in all other states they SHALL be 0/0/000.
REQ-022 ALU-class decode: 000 add (sub if in_sub), 001 sll, 100 xor, 101 srl (sra if in_sub), 110 or, 111 and; 010 and 011 use sub.
REQ-023 ALU-class result: out_result = alu_out, except 010 = {31'b0,less_than} and 011 = {31'b0,less_than_unsigned}; out_taken = 0.
REQ-024 Branch class: alu_op = 001; taken is 000 zero, 001 !zero, 100 less_than, 101 !less_than, 110 less_than_unsigned, 111 !less_than_unsigned, 010/011 0; out_result = 0.
REQ-025 ALU outputs and flags SHALL be sampled only in CAPTURE, latched on the CAPTURE->RESP edge.
REQ-026 out_valid SHALL be 1 exactly in RESP, first asserted two edges after the accept edge.
REQ-027 out_result, out_taken and out_target SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 No new accept while busy; minimum issue interval is 4 cycles with out_ready held 1.
REQ-029 out_target SHALL wrap modulo 2^32 with no overflow indication.

Reset
REQ-030 With reset=1 at a rising edge, state SHALL become IDLE and out_valid, out_taken, out_result and out_target SHALL become 0, irrespective of state.
REQ-031 An instruction in flight at reset SHALL be discarded with no out_valid pulse, and the ALU's un-reset outputs SHALL be ignored.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 ALU add: src1=5, src2=7, funct3=000, sub=0 -> alu_op=000 in ISSUE; out_result=12 two edges after accept.
REQ-034 sra: src1=0x80000000, src2=4, funct3=101, sub=1 -> alu_op=111; out_result=0xF8000000.
REQ-035 slt/sltu: src1=0xFFFFFFFF, src2=1 -> funct3 010 gives out_result=1; funct3 011 gives out_result=0.
REQ-036 Branch: bge src1=3, src2=3, pc=0xFFFFFFF0, imm=0x20 -> out_taken=1, out_target=0x00000010.
REQ-037 Backpressure: out_ready=0 for 5 cycles in RESP -> outputs held and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-038 Reset asserted in CAPTURE -> IDLE next edge, no out_valid, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/exec_seq.sv
// Single-issue execute sequencer: accepts one instruction, drives an external
// registered ALU for one cycle, captures its result/flags and holds the response.
module exec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             zero,
  input  logic             less_than,
  input  logic             less_than_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLL = 3'b101,
                         OP_SRL = 3'b110, OP_SRA = 3'b111;

  state_t           state_q, state_d;
  logic             br_q, br_d;
  logic [2:0]       f3_q, f3_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d, tgt_q, tgt_d;
  logic [WIDTH-1:0] res_q, res_d, otgt_q, otgt_d;
  logic             taken_q, taken_d;
  logic [2:0]       op_dec;
  logic             accept;

  assign accept = in_valid && (state_q == S_IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // branches compare via subtract; slt/sltu also subtract and use the flags
  always_comb begin
    op_dec = OP_ADD;
    if (br_q) op_dec = OP_SUB;
    else begin
      case (f3_q)
        3'b000:          op_dec = sub_q ? OP_SUB : OP_ADD;
        3'b001:          op_dec = OP_SLL;
        3'b010, 3'b011:  op_dec = OP_SUB;
        3'b100:          op_dec = OP_XOR;
        3'b101:          op_dec = sub_q ? OP_SRA : OP_SRL;
        3'b110:          op_dec = OP_OR;
        default:         op_dec = OP_AND;
      endcase
    end
  end

  // output logic
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_RESP);
    alu_in1    = '0;
    alu_in2    = '0;
    alu_op     = OP_ADD;
    if (state_q == S_ISSUE) begin
      alu_in1 = src1_q;
      alu_in2 = src2_q;
      alu_op  = op_dec;
    end
    out_result = res_q;
    out_taken  = taken_q;
    out_target = otgt_q;
  end

  // datapath capture: operands on accept, ALU response only in CAPTURE
  always_comb begin
    br_d    = br_q;
    f3_d    = f3_q;
    sub_d   = sub_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    tgt_d   = tgt_q;
    res_d   = res_q;
    taken_d = taken_q;
    otgt_d  = otgt_q;
    if (accept) begin
      br_d   = (in_class == 2'b01);
      f3_d   = in_funct3;
      sub_d  = in_sub;
      src1_d = in_src1;
      src2_d = in_src2;
      tgt_d  = in_pc + in_imm;
    end
    if (state_q == S_CAPTURE) begin
      otgt_d = tgt_q;
      if (br_q) begin
        res_d = '0;
        case (f3_q)
          3'b000:  taken_d = zero;
          3'b001:  taken_d = !zero;
          3'b100:  taken_d = less_than;
          3'b101:  taken_d = !less_than;
          3'b110:  taken_d = less_than_unsigned;
          3'b111:  taken_d = !less_than_unsigned;
          default: taken_d = 1'b0;
        endcase
      end else begin
        taken_d = 1'b0;
        case (f3_q)
          3'b010:  res_d = {{(WIDTH-1){1'b0}}, less_than};
          3'b011:  res_d = {{(WIDTH-1){1'b0}}, less_than_unsigned};
          default: res_d = alu_out;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_q    <= 1'b0;
      f3_q    <= '0;
      sub_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      tgt_q   <= '0;
      res_q   <= '0;
      taken_q <= 1'b0;
      otgt_q  <= '0;
    end else begin
      br_q    <= br_d;
      f3_q    <= f3_d;
      sub_q   <= sub_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      tgt_q   <= tgt_d;
      res_q   <= res_d;
      taken_q <= taken_d;
      otgt_q  <= otgt_d;
    end
  end

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: registered ALU model, expected-response queue built from
// instruction semantics, and a per-cycle compare process on the response port.
module tb_exec_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_sub;
  logic [1:0]  in_class;
  logic [2:0]  in_funct3, alu_op;
  logic [31:0] in_src1, in_src2, in_pc, in_imm, alu_in1, alu_in2, alu_out;
  logic        zero, less_than, less_than_unsigned;
  logic        out_valid, out_ready, out_taken;
  logic [31:0] out_result, out_target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;
  exp_t exp_q[$];

  exec_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_sub(in_sub),
    .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc), .in_imm(in_imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .zero(zero), .less_than(less_than), .less_than_unsigned(less_than_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_taken(out_taken), .out_target(out_target));

  always #5 clk = ~clk;

  // external ALU: one-cycle registered result and flags, no reset
  always @(posedge clk) begin
    logic [31:0] r;
    case (alu_op)
      3'b000:  r = alu_in1 + alu_in2;
      3'b001:  r = alu_in1 - alu_in2;
      3'b010:  r = alu_in1 & alu_in2;
      3'b011:  r = alu_in1 | alu_in2;
      3'b100:  r = alu_in1 ^ alu_in2;
      3'b101:  r = alu_in1 << alu_in2[4:0];
      3'b110:  r = alu_in1 >> alu_in2[4:0];
      default: r = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
    endcase
    alu_out            <= r;
    zero               <= (r == 32'd0);
    less_than          <= ($signed(alu_in1) < $signed(alu_in2));
    less_than_unsigned <= (alu_in1 < alu_in2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // instruction semantics, independent of the ALU opcode mapping
  function automatic exp_t model(input logic [1:0] cls, input logic [2:0] f3, input logic sub,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm);
    exp_t e;
    e.res = 32'd0; e.taken = 1'b0; e.tgt = pc + imm;
    if (cls == 2'b01) begin
      case (f3)
        3'b000: e.taken = (a == b);
        3'b001: e.taken = (a != b);
        3'b100: e.taken = ($signed(a) < $signed(b));
        3'b101: e.taken = ($signed(a) >= $signed(b));
        3'b110: e.taken = (a < b);
        3'b111: e.taken = (a >= b);
        default: e.taken = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000: e.res = sub ? a - b : a + b;
        3'b001: e.res = a << b[4:0];
        3'b010: e.res = {31'd0, $signed(a) < $signed(b)};
        3'b011: e.res = {31'd0, a < b};
        3'b100: e.res = a ^ b;
        3'b101: e.res = sub ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'b110: e.res = a | b;
        default: e.res = a & b;
      endcase
    end
    return e;
  endfunction

  function automatic logic [2:0] exp_op(input logic [1:0] cls, input logic [2:0] f3, input logic sub);
    if (cls == 2'b01) return 3'b001;
    case (f3)
      3'b000: return sub ? 3'b001 : 3'b000;
      3'b001: return 3'b101;
      3'b100: return 3'b100;
      3'b101: return sub ? 3'b111 : 3'b110;
      3'b110: return 3'b011;
      3'b111: return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // response compare: every cycle a response is presented
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        check("result", out_result, exp_q[0].res);
        check("taken", {31'd0, out_taken}, {31'd0, exp_q[0].taken});
        check("target", out_target, exp_q[0].tgt);
        check("ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // accept one instruction, check ISSUE/CAPTURE outputs, return at first out_valid negedge
  task automatic issue(input logic [1:0] cls, input logic [2:0] f3, input logic sub,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic push);
    int n;
    @(negedge clk);
    in_class = cls; in_funct3 = f3; in_sub = sub;
    in_src1 = a; in_src2 = b; in_pc = pc; in_imm = imm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(model(cls, f3, sub, a, b, pc, imm));
    @(posedge clk); #1 in_valid = 1'b0;
    in_src1 = 32'hDEAD_BEEF; in_src2 = 32'h1234_5678;
    @(negedge clk);
    check("issue_op", {29'd0, alu_op}, {29'd0, exp_op(cls, f3, sub)});
    check("issue_in1", alu_in1, a);
    check("issue_in2", alu_in2, b);
    check("issue_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("capture_idle_alu", {alu_in1 | alu_in2, 29'd0} | {32'd0, alu_op}, 64'd0);
    check("capture_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run(input logic [1:0] cls, input logic [2:0] f3, input logic sub,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic [31:0] imm);
    issue(cls, f3, sub, a, b, pc, imm, 1'b1);
    @(negedge clk);
    check("back_idle", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_funct3 = '0; in_sub = 1'b0;
    in_src1 = '0; in_src2 = '0; in_pc = '0; in_imm = '0;

    // hand-computed pins on the model
    e = model(2'b00, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    check("pin_add", e.res, 32'd12);
    e = model(2'b00, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    check("pin_sra", e.res, 32'hF800_0000);
    e = model(2'b00, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    check("pin_slt", e.res, 32'd1);
    e = model(2'b00, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    check("pin_sltu", e.res, 32'd0);
    e = model(2'b01, 3'b101, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20);
    check("pin_bge", {e.taken, e.tgt}, {1'b1, 32'h0000_0010});
    check("pin_sra_op", {29'd0, exp_op(2'b00, 3'b101, 1'b1)}, 32'd7);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outs", out_result | out_target | {31'd0, out_taken}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    run(2'b00, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    run(2'b00, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    run(2'b00, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    run(2'b00, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    run(2'b00, 3'b000, 1'b1, 32'd3, 32'd10, 32'd0, 32'd0);
    run(2'b00, 3'b001, 1'b0, 32'h0000_00F1, 32'd36, 32'd0, 32'd0);
    run(2'b00, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    run(2'b00, 3'b110, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'd0);
    run(2'b00, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0);
    run(2'b10, 3'b100, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'd0);
    run(2'b11, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    run(2'b01, 3'b000, 1'b0, 32'd9, 32'd9, 32'h100, 32'h8);
    run(2'b01, 3'b001, 1'b0, 32'd9, 32'd9, 32'h100, 32'h8);
    run(2'b01, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFFC);
    run(2'b01, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    run(2'b01, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h4);
    run(2'b01, 3'b010, 1'b0, 32'd1, 32'd1, 32'h10, 32'h10);
    run(2'b01, 3'b101, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20);

    // backpressure: hold for 5 cycles, then release
    @(posedge clk); #1 out_ready = 1'b0;
    issue(2'b00, 3'b100, 1'b0, 32'h1357_9BDF, 32'h0F0F_0F0F, 32'h40, 32'h4, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

    // reset in CAPTURE: in-flight instruction discarded
    @(negedge clk);
    in_class = 2'b01; in_funct3 = 3'b001; in_sub = 1'b0;
    in_src1 = 32'd1; in_src2 = 32'd2; in_pc = 32'h500; in_imm = 32'h5; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstcap_valid", {31'd0, out_valid}, 32'd0);
    check("rstcap_outs", out_result | out_target | {31'd0, out_taken}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rstcap_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("rstcap_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // reset while holding a response
    @(posedge clk); #1 out_ready = 1'b0;
    issue(2'b00, 3'b110, 1'b0, 32'h00FF_0000, 32'h0000_00FF, 32'h80, 32'h80, 1'b1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("rstresp_valid", {31'd0, out_valid}, 32'd0);
    check("rstresp_outs", out_result | out_target | {31'd0, out_taken}, 32'd0);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rstresp_ready", {31'd0, in_ready}, 32'd1);

    run(2'b00, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd2);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
